// File: rtl/up_axi_master.sv
// AXI4-Lite initiator: one word-addressed register command in, one AXI4-Lite transaction out.
// Optional error counter is built only when UP_AXI_MASTER_ERRCNT_EN is defined.
module up_axi_master #(
  parameter int CMD_ADDR_WIDTH = 14,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int ERRCNT_WIDTH   = 16
) (
  input  logic                      m_axi_aclk,
  input  logic                      m_axi_areset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [CMD_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]               cmd_wdata,
  input  logic [3:0]                cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic [ERRCNT_WIDTH-1:0]   err_count,
  input  logic                      err_clr,
  output logic                      m_axi_awvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  input  logic                      m_axi_awready,
  output logic                      m_axi_wvalid,
  output logic [31:0]               m_axi_wdata,
  output logic [3:0]                m_axi_wstrb,
  input  logic                      m_axi_wready,
  input  logic                      m_axi_bvalid,
  input  logic [1:0]                m_axi_bresp,
  output logic                      m_axi_bready,
  output logic                      m_axi_arvalid,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  input  logic                      m_axi_arready,
  input  logic                      m_axi_rvalid,
  input  logic [1:0]                m_axi_rresp,
  input  logic [31:0]               m_axi_rdata,
  output logic                      m_axi_rready
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, RSP} state_t;

  state_t                    state, state_nxt;
  logic                      aw_done, w_done;
  logic [AXI_ADDR_WIDTH-1:0] addr_r;
  logic [31:0]               wdata_r;
  logic [3:0]                wstrb_r;

  assign m_axi_awaddr = addr_r;
  assign m_axi_araddr = addr_r;
  assign m_axi_wdata  = wdata_r;
  assign m_axi_wstrb  = wstrb_r;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) state <= IDLE;
    else              state <= state_nxt;
  end

  // Handshake-facing signals decode straight from the state so reset clears them at once.
  always_comb begin
    state_nxt     = state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = ~m_axi_areset;
        if (cmd_valid && !m_axi_areset) state_nxt = cmd_write ? WR : RADDR;
      end
      WR: begin
        m_axi_awvalid = ~aw_done;
        m_axi_wvalid  = ~w_done;
        if ((aw_done || m_axi_awready) && (w_done || m_axi_wready)) state_nxt = WRESP;
      end
      WRESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_nxt = RSP;
      end
      RADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RDATA;
      end
      RDATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid) state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // AW and W complete independently; each flag retires its own valid.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == IDLE) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state == WR) begin
      if (m_axi_awvalid && m_axi_awready) aw_done <= 1'b1;
      if (m_axi_wvalid && m_axi_wready)   w_done  <= 1'b1;
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      addr_r  <= '0;
      wdata_r <= '0;
      wstrb_r <= '0;
    end else if (state == IDLE && cmd_valid) begin
      addr_r  <= {cmd_addr, 2'b00};
      wdata_r <= cmd_wdata;
      wstrb_r <= cmd_wstrb;
    end
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else if (state == WRESP && m_axi_bvalid) begin
      rsp_rdata <= '0;
      rsp_resp  <= m_axi_bresp;
    end else if (state == RDATA && m_axi_rvalid) begin
      rsp_rdata <= m_axi_rdata;
      rsp_resp  <= m_axi_rresp;
    end
  end

`ifdef UP_AXI_MASTER_ERRCNT_EN
  logic       resp_cap;
  logic [1:0] resp_code;

  assign resp_cap  = (m_axi_bvalid && m_axi_bready) || (m_axi_rvalid && m_axi_rready);
  assign resp_code = m_axi_bready ? m_axi_bresp : m_axi_rresp;

  // Clear wins over a coincident error; the count sticks at all-ones.
  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset)                                          err_count <= '0;
    else if (err_clr)                                          err_count <= '0;
    else if (resp_cap && resp_code != 2'b00 && !(&err_count))  err_count <= err_count + 1'b1;
  end
`else
  logic unused_err_clr;

  assign err_count      = '0;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_up_axi_master.sv
// Scoreboard bench for up_axi_master: randomized AXI4-Lite slave with wait states and error
// responses, a reference register memory, and a decoupled response monitor.
module tb_up_axi_master;

  localparam int CAW = 14;
  localparam int AAW = 16;
  localparam int EW  = 16;
`ifdef UP_AXI_MASTER_ERRCNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_ready, cmd_write;
  logic [CAW-1:0] cmd_addr;
  logic [31:0]    cmd_wdata;
  logic [3:0]     cmd_wstrb;
  logic           rsp_valid, rsp_ready;
  logic [31:0]    rsp_rdata;
  logic [1:0]     rsp_resp;
  logic [EW-1:0]  err_count;
  logic           err_clr;
  logic           m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [AAW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]     m_axi_awprot, m_axi_arprot;
  logic [31:0]    m_axi_wdata, m_axi_rdata;
  logic [3:0]     m_axi_wstrb;
  logic           m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic           m_axi_rvalid, m_axi_rready;
  logic [1:0]     m_axi_bresp, m_axi_rresp;

  always #5 clk = ~clk;

  up_axi_master #(.CMD_ADDR_WIDTH(CAW), .AXI_ADDR_WIDTH(AAW), .ERRCNT_WIDTH(EW)) dut (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .err_count(err_count), .err_clr(err_clr),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
    .m_axi_awready(m_axi_awready),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
    .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rresp(m_axi_rresp), .m_axi_rdata(m_axi_rdata),
    .m_axi_rready(m_axi_rready)
  );

  typedef struct {
    bit             wr;
    logic [AAW-1:0] addr;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic [1:0]     resp;
    bit             clr;
  } axi_exp_t;

  typedef struct {
    bit            wr;
    logic [31:0]   rdata;
    logic [1:0]    resp;
    logic [EW-1:0] err;
  } rsp_exp_t;

  axi_exp_t      axi_q[$];
  rsp_exp_t      rsp_q[$];
  logic [31:0]   ref_mem[int];
  logic [31:0]   smem[int];
  logic [EW-1:0] err_model = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0, rsp_stall = 0;
  int aw_hi = 0, w_hi = 0, aw_n = 0, w_n = 0;
  int last_acc_cyc = 0, last_first_cyc = 0, last_hs_cyc = 0;
  logic [AAW-1:0] s_last_aw = '0, s_last_ar = '0;
  logic [31:0]    last_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name, string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endfunction

  // Reference register bank: power-up contents plus byte-strobed writes.
  function automatic logic [31:0] init_word(int w);
    return (w == 2) ? 32'h47465550 : (32'hC0DE0000 | 32'(w));
  endfunction

  function automatic logic [31:0] ref_read(int w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic void ref_write(int w, logic [31:0] d, logic [3:0] s);
    logic [31:0] cur;
    cur = ref_read(w);
    for (int b = 0; b < 4; b++)
      if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    ref_mem[w] = cur;
  endfunction

  function automatic logic [EW-1:0] next_err(logic [EW-1:0] cur, logic [1:0] resp, bit clr);
    logic [EW-1:0] n;
    n = clr ? '0 : ((resp != 2'b00 && cur != '1) ? cur + 1'b1 : cur);
    return ERR_EN ? n : '0;
  endfunction

  task automatic do_cmd(bit wr, int word, logic [31:0] d, logic [3:0] s, logic [1:0] resp, bit clr);
    axi_exp_t       a;
    rsp_exp_t       r;
    logic [CAW-1:0] wa;
    int             n;
    wa = CAW'(word);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = wa; cmd_wdata = d; cmd_wstrb = s;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      fail_now("cmd_accept_timeout", "cmd_ready never rose, required 1");
      cmd_valid = 1'b0;
      return;
    end
    last_acc_cyc = cyc;
    a.wr = wr; a.addr = {wa, 2'b00}; a.wdata = d; a.wstrb = s; a.resp = resp; a.clr = clr;
    r.wr = wr; r.rdata = wr ? 32'h0 : ref_read(word); r.resp = resp;
    err_model = next_err(err_model, resp, clr);
    r.err = err_model;
    if (wr) ref_write(word, d, s);
    axi_q.push_back(a);
    rsp_q.push_back(r);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(string name);
    int n;
    n = 0;
    while ((rsp_q.size() != 0 || cmd_ready !== 1'b1) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({name, "_outstanding"}, rsp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_ctrl"}, {cmd_ready, rsp_valid, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                           m_axi_arvalid, m_axi_rready}, 0);
    check({tag, "_rsp"}, {rsp_rdata, rsp_resp}, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_addr"}, {m_axi_awaddr, m_axi_araddr}, 0);
    check({tag, "_wdata"}, {m_axi_wdata, m_axi_wstrb}, 0);
  endtask

  // AXI4-Lite slave with programmable wait states; responses come from the expected queue.
  initial begin : slave
    bit             aw_hs_l, w_hs_l, b_hs_l, ar_hs_l, r_hs_l, have_aw, have_w, have_ar;
    logic [AAW-1:0] aw_a, ar_a;
    logic [31:0]    w_d, m;
    logic [3:0]     w_s;
    int             aw_c, w_c, b_c, ar_c, r_c, w;
    axi_exp_t       e;
    {aw_hs_l, w_hs_l, b_hs_l, ar_hs_l, r_hs_l, have_aw, have_w, have_ar} = '0;
    aw_a = '0; ar_a = '0; w_d = '0; w_s = '0;
    {aw_c, w_c, b_c, ar_c, r_c} = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rresp = 0; m_axi_rdata = 0; err_clr = 0;
    forever begin
      @(negedge clk);
      err_clr = 1'b0;
      if (rst) begin
        {aw_hs_l, w_hs_l, b_hs_l, ar_hs_l, r_hs_l, have_aw, have_w, have_ar} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_arready = 0; m_axi_rvalid = 0;
        continue;
      end
      if (aw_hs_l) begin have_aw = 1; aw_n++; aw_c = 0; s_last_aw = aw_a; end
      if (w_hs_l)  begin have_w = 1; w_n++; w_c = 0; end
      if (b_hs_l)  m_axi_bvalid = 0;
      if (ar_hs_l) begin have_ar = 1; ar_c = 0; s_last_ar = ar_a; end
      if (r_hs_l)  m_axi_rvalid = 0;
      if (m_axi_awvalid) aw_hi++;
      if (m_axi_wvalid)  w_hi++;
      if (have_aw && have_w && !m_axi_bvalid) begin
        if (b_c >= b_dly) begin
          if (axi_q.size() == 0) fail_now("unexpected_write", "write reached slave with no command issued");
          else begin
            e = axi_q.pop_front();
            check("txn_is_write", 1, e.wr);
            check("awaddr", aw_a, e.addr);
            check("wdata", w_d, e.wdata);
            check("wstrb", w_s, e.wstrb);
            m = {{8{w_s[3]}}, {8{w_s[2]}}, {8{w_s[1]}}, {8{w_s[0]}}};
            w = int'(aw_a >> 2);
            smem[w] = ((smem.exists(w) ? smem[w] : init_word(w)) & ~m) | (w_d & m);
            m_axi_bresp = e.resp;
            err_clr = e.clr;
          end
          m_axi_bvalid = 1; have_aw = 0; have_w = 0; b_c = 0;
        end else b_c++;
      end
      if (have_ar && !m_axi_rvalid) begin
        if (r_c >= r_dly) begin
          if (axi_q.size() == 0) fail_now("unexpected_read", "read reached slave with no command issued");
          else begin
            e = axi_q.pop_front();
            check("txn_is_read", 0, e.wr);
            check("araddr", ar_a, e.addr);
            m_axi_rresp = e.resp;
            err_clr = e.clr;
          end
          w = int'(ar_a >> 2);
          m_axi_rdata = smem.exists(w) ? smem[w] : init_word(w);
          m_axi_rvalid = 1; have_ar = 0; r_c = 0;
        end else r_c++;
      end
      m_axi_awready = m_axi_awvalid && !have_aw && (aw_c >= aw_dly);
      if (m_axi_awvalid && !have_aw && !m_axi_awready) aw_c++;
      m_axi_wready = m_axi_wvalid && !have_w && (w_c >= w_dly);
      if (m_axi_wvalid && !have_w && !m_axi_wready) w_c++;
      m_axi_arready = m_axi_arvalid && !have_ar && !m_axi_rvalid && (ar_c >= ar_dly);
      if (m_axi_arvalid && !have_ar && !m_axi_rvalid && !m_axi_arready) ar_c++;
      aw_hs_l = m_axi_awvalid && m_axi_awready;
      if (aw_hs_l) begin
        aw_a = m_axi_awaddr;
        check("awprot", m_axi_awprot, 0);
      end
      w_hs_l = m_axi_wvalid && m_axi_wready;
      if (w_hs_l) begin w_d = m_axi_wdata; w_s = m_axi_wstrb; end
      b_hs_l = m_axi_bvalid && m_axi_bready;
      ar_hs_l = m_axi_arvalid && m_axi_arready;
      if (ar_hs_l) begin
        ar_a = m_axi_araddr;
        check("arprot", m_axi_arprot, 0);
      end
      r_hs_l = m_axi_rvalid && m_axi_rready;
    end
  end

  // Response monitor: drives rsp_ready and pops the scoreboard on each handshake.
  initial begin : rsp_mon
    bit          seen;
    logic [31:0] pd;
    logic [1:0]  pr;
    int          st;
    rsp_exp_t    r;
    rsp_ready = 0; seen = 0; st = 0; pd = '0; pr = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin rsp_ready = 0; seen = 0; st = 0; continue; end
      if (rsp_valid) begin
        check("cmd_ready_in_rsp", cmd_ready, 0);
        if (!seen) begin
          last_first_cyc = cyc; seen = 1; pd = rsp_rdata; pr = rsp_resp;
        end else begin
          check("rsp_rdata_stable", rsp_rdata, pd);
          check("rsp_resp_stable", rsp_resp, pr);
        end
        if (st >= rsp_stall) begin
          rsp_ready = 1; last_hs_cyc = cyc; last_rdata = rsp_rdata;
          if (rsp_q.size() == 0) fail_now("unexpected_rsp", "response with nothing outstanding");
          else begin
            r = rsp_q.pop_front();
            check(r.wr ? "wr_rsp_rdata" : "rd_rsp_rdata", rsp_rdata, r.rdata);
            check("rsp_resp", rsp_resp, r.resp);
            check("err_count", err_count, r.err);
          end
          seen = 0; st = 0;
        end else begin
          rsp_ready = 0;
          st++;
        end
      end else rsp_ready = 0;
    end
  end

  // Protocol monitor: valids hold with stable payload, and exactly one phase is active.
  initial begin : proto_mon
    bit             p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [AAW-1:0] p_awa, p_ara;
    logic [35:0]    p_w;
    int             k;
    {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0;
    p_awa = '0; p_ara = '0; p_w = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin {p_awv, p_awr, p_wv, p_wr, p_arv, p_arr} = '0; continue; end
      if (p_awv && !p_awr) begin
        check("awvalid_hold", m_axi_awvalid, 1);
        check("awaddr_stable", m_axi_awaddr, p_awa);
      end
      if (p_wv && !p_wr) begin
        check("wvalid_hold", m_axi_wvalid, 1);
        check("wdata_stable", {m_axi_wdata, m_axi_wstrb}, p_w);
      end
      if (p_arv && !p_arr) begin
        check("arvalid_hold", m_axi_arvalid, 1);
        check("araddr_stable", m_axi_araddr, p_ara);
      end
      k = int'(cmd_ready) + int'(m_axi_awvalid | m_axi_wvalid) + int'(m_axi_bready) +
          int'(m_axi_arvalid) + int'(m_axi_rready) + int'(rsp_valid);
      check("one_active_phase", k, 1);
      p_awv = m_axi_awvalid; p_awr = m_axi_awready; p_awa = m_axi_awaddr;
      p_wv = m_axi_wvalid; p_wr = m_axi_wready; p_w = {m_axi_wdata, m_axi_wstrb};
      p_arv = m_axi_arvalid; p_arr = m_axi_arready; p_ara = m_axi_araddr;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    #3;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    // Zero-wait write of word 3.
    do_cmd(1'b1, 3, 32'h12345678, 4'hF, 2'b00, 1'b0);
    wait_idle("t_write");
    check("t_write_awaddr", s_last_aw, 16'h000C);
    check("t_write_latency", last_first_cyc - last_acc_cyc, 3);

    // Read of the MAGIC word.
    do_cmd(1'b0, 2, 32'h0, 4'h0, 2'b00, 1'b0);
    wait_idle("t_read");
    check("t_read_araddr", s_last_ar, 16'h0008);
    check("t_read_rdata", last_rdata, 32'h47465550);
    check("t_read_latency", last_first_cyc - last_acc_cyc, 3);

    // Write with W held off while AW completes at once.
    aw_hi = 0; w_hi = 0; aw_n = 0; w_n = 0; w_dly = 4;
    do_cmd(1'b1, 4, 32'hCAFEF00D, 4'h5, 2'b00, 1'b0);
    wait_idle("t_slow_w");
    check("t_slow_w_awvalid_cycles", aw_hi, 1);
    check("t_slow_w_wvalid_cycles", w_hi, 5);
    check("t_slow_w_handshakes", {aw_n[7:0], w_n[7:0]}, 16'h0101);
    w_dly = 0;

    // Error responses, then a clear coinciding with another error.
    do_cmd(1'b1, 6, 32'h0BADBEEF, 4'hF, 2'b10, 1'b0);
    do_cmd(1'b0, 6, 32'h0, 4'h0, 2'b11, 1'b0);
    wait_idle("t_err");
    check("t_err_count_two", err_count, ERR_EN ? 2 : 0);
    do_cmd(1'b1, 7, 32'h00000001, 4'h1, 2'b10, 1'b1);
    wait_idle("t_err_clr");
    check("t_err_count_cleared", err_count, 0);

    // Response back-pressure with the next command already waiting.
    rsp_stall = 10;
    do_cmd(1'b0, 4, 32'h0, 4'h0, 2'b00, 1'b0);
    do_cmd(1'b1, 8, 32'h55AA55AA, 4'hF, 2'b00, 1'b0);
    rsp_stall = 0;
    check("t_stall_accept_after_rsp", last_acc_cyc, last_hs_cyc + 1);
    wait_idle("t_stall");

    // Randomized traffic against the reference bank.
    for (int i = 0; i < 60; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3); rsp_stall = $urandom_range(0, 2);
      do_cmd(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)),
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             $urandom_range(0, 9) == 0);
    end
    wait_idle("t_random");
    {aw_dly, w_dly, b_dly, ar_dly, rsp_stall} = '0;

    // Reset while the slave withholds read data.
    r_dly = 1000;
    do_cmd(1'b0, 7, 32'h0, 4'h0, 2'b00, 1'b0);
    n = 0;
    while (m_axi_rready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("t_reset_reached_rdata", m_axi_rready, 1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("t_midreset");
    axi_q.delete();
    rsp_q.delete();
    err_model = '0;
    r_dly = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    do_cmd(1'b0, 5, 32'h0, 4'h0, 2'b00, 1'b0);
    wait_idle("t_after_reset");
    check("t_after_reset_araddr", s_last_ar, 16'h0014);
    check("t_after_reset_rdata", last_rdata, ref_read(5));

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
